// File: rtl/trg_counter.sv
// Run-controlled trigger counter with bus-generated software events and lane-selected event inputs.
// Optional timestamp capture is enabled by defining TRG_COUNTER_TIMESTAMP_EN.
module trg_counter #(
  parameter int EN = 1,
  parameter int TN = 1,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EN-1:0] evi_rst,
  input  logic [EN-1:0] evi_str,
  input  logic [EN-1:0] evi_stp,
  input  logic [EN-1:0] evi_swt,
  output logic          evo_rst,
  output logic          evo_str,
  output logic          evo_stp,
  output logic          evo_swt,
  input  logic [TN-1:0] trg,
  output logic          tro,
  input  logic          bus_wen,
  input  logic          bus_ren,
  input  logic [31:0]   bus_addr,
  input  logic [31:0]   bus_wdata,
  output logic [31:0]   bus_rdata,
  output logic          bus_ack,
  output logic          bus_err
);

  localparam int SW = (EN > 1) ? $clog2(EN) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [TN-1:0] msk_q, msk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    evo_q, evo_d;
  logic          tro_q, tro_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   tsp_rd;

  logic ev_rst, ev_str, ev_stp, ev_swt;
  logic run, trg_hit, trig;

  logic unused;
  assign unused = ^{bus_addr[31:5], bus_wdata};

  // Lanes beyond EN never match, so an out-of-range select yields no events.
  always_comb begin
    ev_rst = 1'b0;
    ev_str = 1'b0;
    ev_stp = 1'b0;
    ev_swt = 1'b0;
    for (int i = 0; i < EN; i++) begin
      if (sel_q == SW'(i)) begin
        ev_rst = evi_rst[i];
        ev_str = evi_str[i];
        ev_stp = evi_stp[i];
        ev_swt = evi_swt[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    msk_d   = msk_q;
    cnt_d   = cnt_q;
    evo_d   = 4'b0000;
    ack_d   = bus_wen | bus_ren;
    rdata_d = 32'd0;

    run     = (state_q == ST_RUN);
    trg_hit = |(trg & msk_q);
    trig    = run & (trg_hit | ev_swt);
    tro_d   = trig;

    if (bus_wen) begin
      case (bus_addr[4:0])
        5'h00:   evo_d = bus_wdata[3:0];
        5'h04:   sel_d = bus_wdata[SW-1:0];
        5'h08:   msk_d = bus_wdata[TN-1:0];
        default: ;
      endcase
    end

    if (bus_ren) begin
      case (bus_addr[4:0])
        5'h00:   rdata_d = {30'd0, run, 1'b0};
        5'h04:   rdata_d = 32'(sel_q);
        5'h08:   rdata_d = 32'(msk_q);
        5'h0C:   rdata_d = 32'(cnt_q);
        5'h10:   rdata_d = tsp_rd;
        default: rdata_d = 32'd0;
      endcase
    end

    // Reset event wins over stop, which wins over start.
    if (ev_rst) begin
      state_d = ST_IDLE;
    end else if (ev_stp && state_q == ST_RUN) begin
      state_d = ST_IDLE;
    end else if (ev_str && state_q == ST_IDLE) begin
      state_d = ST_RUN;
    end

    if (ev_rst) begin
      cnt_d = '0;
    end else if (trig && cnt_q != {CW{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      msk_q   <= '0;
      cnt_q   <= '0;
      evo_q   <= 4'b0000;
      tro_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      msk_q   <= msk_d;
      cnt_q   <= cnt_d;
      evo_q   <= evo_d;
      tro_q   <= tro_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef TRG_COUNTER_TIMESTAMP_EN
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] tsp_q, tsp_d;

  always_comb begin
    tmr_d = tmr_q;
    tsp_d = tsp_q;
    if (ev_rst) begin
      tmr_d = 32'd0;
    end else if (run) begin
      tmr_d = tmr_q + 32'd1;
    end
    if (trig) begin
      tsp_d = tmr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= 32'd0;
      tsp_q <= 32'd0;
    end else begin
      tmr_q <= tmr_d;
      tsp_q <= tsp_d;
    end
  end

  assign tsp_rd = tsp_q;
`else
  assign tsp_rd = 32'd0;
`endif

  assign evo_rst   = evo_q[0];
  assign evo_str   = evo_q[1];
  assign evo_stp   = evo_q[2];
  assign evo_swt   = evo_q[3];
  assign tro       = tro_q;
  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  assign bus_err   = 1'b0;

endmodule

// File: tb/tb_trg_counter.sv
// Directed bench for trg_counter with software events looped back onto lane 0.
// Built with CW=4 so counter saturation is reachable in a short run.
module tb_trg_counter;

  localparam int EN = 1;
  localparam int TN = 2;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [EN-1:0] evi_rst, evi_str, evi_stp, evi_swt;
  logic          evo_rst, evo_str, evo_stp, evo_swt;
  logic [TN-1:0] trg;
  logic          tro;
  logic          bus_wen, bus_ren;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata;
  logic          bus_ack, bus_err;

  int checks;
  int failures;

  trg_counter #(.EN(EN), .TN(TN), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .evi_rst   (evi_rst),
    .evi_str   (evi_str),
    .evi_stp   (evi_stp),
    .evi_swt   (evi_swt),
    .evo_rst   (evo_rst),
    .evo_str   (evo_str),
    .evo_stp   (evo_stp),
    .evo_swt   (evo_swt),
    .trg       (trg),
    .tro       (tro),
    .bus_wen   (bus_wen),
    .bus_ren   (bus_ren),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  assign evi_rst = evo_rst;
  assign evi_str = evo_str;
  assign evi_stp = evo_stp;
  assign evi_swt = evo_swt;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Driver tasks: every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_wen   = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    tick();
    bus_wen   = 1'b0;
    bus_wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic ack);
    bus_ren  = 1'b1;
    bus_addr = addr;
    tick();
    bus_ren  = 1'b0;
    data     = bus_rdata;
    ack      = bus_ack;
  endtask

  task automatic pulse_trg(input logic [TN-1:0] val, output logic tro_seen);
    trg = val;
    tick();
    tro_seen = tro;
    trg = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        ack;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus_ack, bus_rdata, evo_rst, evo_str, evo_stp, evo_swt, tro, bus_err} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b rdata=%h evo=%b%b%b%b tro=%b err=%b expected all 0",
               bus_ack, bus_rdata, evo_rst, evo_str, evo_stp, evo_swt, tro, bus_err);
    end
    rst = 1'b0;
    tick();
    bus_read(32'h00, rd, ack);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_ctl: ack=%b rdata=%h expected ack=1 rdata=0", ack, rd);
    end
    tick();
    checks++;
    if (bus_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_single_cycle: ack=%b expected 0", bus_ack);
    end
    bus_read(32'h0C, rd, ack);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt: ack=%b rdata=%h expected ack=1 rdata=0", ack, rd);
    end
    bus_read(32'h08, rd, ack);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_msk: ack=%b rdata=%h expected ack=1 rdata=0", ack, rd);
    end
    bus_read(32'h10, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL tsp_absent: rdata=%h expected 0", rd);
    end
    bus_write(32'h14, 32'hFFFF_FFFF);
    checks++;
    if (bus_ack !== 1'b1 || {evo_rst, evo_str, evo_stp, evo_swt} !== 4'b0000) begin
      failures++;
      $display("FAIL unmapped_write: ack=%b evo=%b%b%b%b expected ack=1 evo=0000",
               bus_ack, evo_rst, evo_str, evo_stp, evo_swt);
    end
    bus_read(32'h14, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_read: rdata=%h expected 0", rd);
    end
    bus_read(32'h08, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_no_side_effect: msk=%h expected 0", rd);
    end
  endtask

  task automatic test_start();
    logic [31:0] rd;
    logic        ack;
    bus_write(32'h04, 32'd0);
    bus_write(32'h08, 32'd1);
    bus_read(32'h08, rd, ack);
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL msk_rw: rdata=%h expected 1", rd);
    end
    bus_write(32'h00, 32'h2);
    checks++;
    if ({evo_rst, evo_str, evo_stp, evo_swt} !== 4'b0100) begin
      failures++;
      $display("FAIL evo_str_pulse: evo=%b%b%b%b expected 0100", evo_rst, evo_str, evo_stp, evo_swt);
    end
    tick();
    checks++;
    if (evo_str !== 1'b0) begin
      failures++;
      $display("FAIL evo_str_width: evo_str=%b expected 0", evo_str);
    end
    bus_read(32'h00, rd, ack);
    checks++;
    if (rd !== 32'h2) begin
      failures++;
      $display("FAIL run_after_start: ctl=%h expected 2", rd);
    end
  endtask

  task automatic test_triggers();
    logic [31:0] rd;
    logic        ack;
    logic        seen;
    int          bad;
    bus_write(32'h00, 32'h8);
    tick();
    checks++;
    if (tro !== 1'b1) begin
      failures++;
      $display("FAIL sw_trigger_tro: tro=%b expected 1", tro);
    end
    tick();
    checks++;
    if (tro !== 1'b0) begin
      failures++;
      $display("FAIL sw_trigger_once: tro=%b expected 0", tro);
    end
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL sw_trigger_cnt: cnt=%0d expected 1", rd);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      pulse_trg(2'b01, seen);
      if (seen !== 1'b1) bad++;
      tick();
      if (tro !== 1'b0) bad++;
      repeat (3) tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hw_trigger_tro: %0d tro errors over 8 pulses, expected 0", bad);
    end
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd9) begin
      failures++;
      $display("FAIL hw_trigger_cnt: cnt=%0d expected 9", rd);
    end
  endtask

  task automatic test_stop_reset();
    logic [31:0] rd;
    logic        ack;
    logic        seen;
    int          bad;
    bus_write(32'h00, 32'h4);
    tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_trg(2'b01, seen);
      if (seen !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stopped_no_tro: %0d tro pulses while stopped, expected 0", bad);
    end
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd9) begin
      failures++;
      $display("FAIL stop_holds_cnt: cnt=%0d expected 9", rd);
    end
    bus_read(32'h00, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL run_after_stop: ctl=%h expected 0", rd);
    end
    bus_write(32'h00, 32'h1);
    tick();
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_clears_cnt: cnt=%0d expected 0", rd);
    end
  endtask

  task automatic test_mask();
    logic [31:0] rd;
    logic        ack;
    logic        seen;
    int          bad;
    bus_write(32'h08, 32'd0);
    bus_write(32'h00, 32'h2);
    tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_trg(2'b11, seen);
      if (seen !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mask_zero_tro: %0d tro pulses with MSK=0, expected 0", bad);
    end
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL mask_zero_cnt: cnt=%0d expected 0", rd);
    end
    bus_write(32'h08, 32'd2);
    pulse_trg(2'b01, seen);
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mask_bit0_blocked: tro=%b expected 0", seen);
    end
    tick();
    pulse_trg(2'b10, seen);
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL mask_bit1_passes: tro=%b expected 1", seen);
    end
    tick();
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL mask_cnt: cnt=%0d expected 1", rd);
    end
  endtask

  task automatic test_sel_range();
    logic [31:0] rd;
    logic        ack;
    bus_write(32'h00, 32'h4);
    tick();
    bus_write(32'h04, 32'd1);
    bus_read(32'h04, rd, ack);
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL sel_rw: sel=%h expected 1", rd);
    end
    bus_write(32'h00, 32'h2);
    tick();
    bus_read(32'h00, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL sel_out_of_range: ctl=%h expected 0", rd);
    end
    bus_write(32'h04, 32'd0);
    bus_write(32'h00, 32'h2);
    tick();
    bus_read(32'h00, rd, ack);
    checks++;
    if (rd !== 32'h2) begin
      failures++;
      $display("FAIL sel_restart: ctl=%h expected 2", rd);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd;
    logic        ack;
    bus_write(32'h00, 32'h8);
    trg = 2'b10;
    tick();
    trg = '0;
    checks++;
    if (tro !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_tro: tro=%b expected 1", tro);
    end
    tick();
    checks++;
    if (tro !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_once: tro=%b expected 0", tro);
    end
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd2) begin
      failures++;
      $display("FAIL same_cycle_cnt: cnt=%0d expected 2", rd);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] rd;
    logic        ack;
    logic        seen;
    for (int i = 0; i < 20; i++) begin
      pulse_trg(2'b10, seen);
      tick();
    end
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd15) begin
      failures++;
      $display("FAIL saturate_cnt: cnt=%0d expected 15", rd);
    end
    pulse_trg(2'b10, seen);
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL saturate_tro: tro=%b expected 1", seen);
    end
    tick();
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd15) begin
      failures++;
      $display("FAIL saturate_hold: cnt=%0d expected 15", rd);
    end
    bus_write(32'h00, 32'h1);
    tick();
    bus_read(32'h0C, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL midrun_reset_cnt: cnt=%0d expected 0", rd);
    end
    bus_read(32'h00, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL midrun_reset_idle: ctl=%h expected 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        ack;
    bus_write(32'h00, 32'hF);
    checks++;
    if ({evo_rst, evo_str, evo_stp, evo_swt} !== 4'b1111) begin
      failures++;
      $display("FAIL evo_all_pulse: evo=%b%b%b%b expected 1111", evo_rst, evo_str, evo_stp, evo_swt);
    end
    tick();
    checks++;
    if ({evo_rst, evo_str, evo_stp, evo_swt, tro} !== 5'b00000) begin
      failures++;
      $display("FAIL evo_all_clear: evo=%b%b%b%b tro=%b expected 0000 0",
               evo_rst, evo_str, evo_stp, evo_swt, tro);
    end
    bus_read(32'h00, rd, ack);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL rst_beats_str: ctl=%h expected 0", rd);
    end
    bus_ren  = 1'b1;
    bus_addr = 32'h08;
    tick();
    checks++;
    if (bus_ack !== 1'b1 || bus_rdata !== 32'd2) begin
      failures++;
      $display("FAIL b2b_read0: ack=%b rdata=%h expected ack=1 rdata=2", bus_ack, bus_rdata);
    end
    bus_addr = 32'h04;
    tick();
    bus_ren = 1'b0;
    checks++;
    if (bus_ack !== 1'b1 || bus_rdata !== 32'd0) begin
      failures++;
      $display("FAIL b2b_read1: ack=%b rdata=%h expected ack=1 rdata=0", bus_ack, bus_rdata);
    end
    tick();
    checks++;
    if (bus_ack !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: ack=%b err=%b expected 0 0", bus_ack, bus_err);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    trg       = '0;
    bus_wen   = 1'b0;
    bus_ren   = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    tick();
    test_reset();
    test_start();
    test_triggers();
    test_stop_reset();
    test_mask();
    test_sel_range();
    test_same_cycle();
    test_saturate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
